// File: rtl/cic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cic_ctrl_pkg
// Desc    : Shared types and constants for the CIC decimator sequencer
// Rev     : 1.0 - initial release
// ============================================================================
package cic_ctrl_pkg;

  localparam int SEL_W      = 2;
  localparam int NUM_CH_MAX = 4;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INTEG      = 3'd1,
    S_COMB_ISSUE = 3'd2,
    S_COMB_WAIT  = 3'd3,
    S_OUT        = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cic_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cic_ctrl
// Desc    : Sequencer for a time-multiplexed CIC decimator (integrator + comb)
// Rev     : 1.0 - initial release
// ============================================================================
module cic_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 10,
  parameter int COMB_STAGES = 5
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cfg_en_i,
  input  logic             cfg_clr_i,
  input  logic [SEL_W-1:0] cfg_nch_i,
  input  logic [CNT_W-1:0] cfg_decim_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             integ_en_o,
  output logic [SEL_W-1:0] integ_sel_o,
  output logic             comb_en_o,
  output logic [SEL_W-1:0] comb_sel_o,
  output logic             clr_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SEL_W-1:0] out_ch_o,
  output logic             ovr_o
);

  localparam int               C_NCH     = (NUM_CH > NUM_CH_MAX) ? NUM_CH_MAX : NUM_CH;
  localparam logic [SEL_W-1:0] C_NCH_MAX = SEL_W'(C_NCH - 1);
  localparam int               C_WAIT_W  = $clog2(COMB_STAGES + 1);

  state_t              r_state;
  state_t              w_next;
  logic [SEL_W-1:0]    r_ch;
  logic [SEL_W-1:0]    r_cch;
  logic [SEL_W-1:0]    r_nch;
  logic [CNT_W-1:0]    r_dec;
  logic [CNT_W-1:0]    r_decim;
  logic [C_WAIT_W-1:0] r_wait;
  logic                r_en_d;
  logic                r_clr;
  logic                r_ovr;

  logic             w_clr_req;
  logic             w_ready;
  logic             w_accept;
  logic             w_wrap;
  logic             w_frame_done;
  logic             w_busy;
  logic [SEL_W-1:0] w_nch_lim;

  // A falling enable only counts as a clear once the filter is running.
  assign w_clr_req    = cfg_clr_i | (r_en_d & ~cfg_en_i & (r_state != S_IDLE));
  assign w_ready      = (r_state == S_INTEG) & cfg_en_i & ~cfg_clr_i;
  assign w_accept     = w_ready & in_valid_i;
  assign w_wrap       = (r_ch == r_nch);
  assign w_frame_done = w_wrap & (r_dec == r_decim);
  assign w_busy       = (r_state == S_COMB_ISSUE) | (r_state == S_COMB_WAIT) | (r_state == S_OUT);
  assign w_nch_lim    = (cfg_nch_i > C_NCH_MAX) ? C_NCH_MAX : cfg_nch_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_clr_req) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:       if (cfg_en_i) w_next = S_INTEG;
        S_INTEG:      if (w_accept && w_frame_done) w_next = S_COMB_ISSUE;
        // Residency in COMB_WAIT is trimmed so valid lands COMB_STAGES after the issue cycle.
        S_COMB_ISSUE: w_next = (COMB_STAGES == 1) ? S_OUT : S_COMB_WAIT;
        S_COMB_WAIT:  if (r_wait <= C_WAIT_W'(1)) w_next = S_OUT;
        S_OUT:        if (out_ready_i) w_next = (r_cch == r_nch) ? S_INTEG : S_COMB_ISSUE;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = w_ready;
    integ_en_o  = w_accept;
    integ_sel_o = w_accept ? r_ch : '0;
    comb_en_o   = (r_state == S_COMB_ISSUE);
    comb_sel_o  = (r_state == S_COMB_ISSUE) ? r_cch : '0;
    out_valid_o = (r_state == S_OUT);
    out_ch_o    = (r_state == S_OUT) ? r_cch : '0;
    clr_o       = r_clr;
    ovr_o       = r_ovr;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ch    <= '0;
      r_cch   <= '0;
      r_dec   <= '0;
      r_wait  <= '0;
      r_nch   <= '0;
      r_decim <= '0;
      r_en_d  <= 1'b0;
      r_clr   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_en_d <= cfg_en_i;
      r_clr  <= w_clr_req;
      if (w_clr_req) begin
        r_ch   <= '0;
        r_cch  <= '0;
        r_dec  <= '0;
        r_wait <= '0;
        r_ovr  <= 1'b0;
      end else begin
        if (in_valid_i && w_busy) begin
          r_ovr <= 1'b1;
        end
        unique case (r_state)
          S_IDLE: begin
            if (cfg_en_i) begin
              r_nch   <= w_nch_lim;
              r_decim <= cfg_decim_i;
              r_ch    <= '0;
              r_cch   <= '0;
              r_dec   <= '0;
              r_wait  <= '0;
            end
          end
          S_INTEG: begin
            if (w_accept) begin
              if (w_wrap) begin
                r_ch <= '0;
                if (w_frame_done) begin
                  r_dec <= '0;
                  r_cch <= '0;
                end else begin
                  r_dec <= r_dec + CNT_W'(1);
                end
              end else begin
                r_ch <= r_ch + SEL_W'(1);
              end
            end
          end
          S_COMB_ISSUE: r_wait <= C_WAIT_W'(COMB_STAGES - 1);
          S_COMB_WAIT: begin
            if (r_wait != '0) r_wait <= r_wait - C_WAIT_W'(1);
          end
          S_OUT: begin
            if (out_ready_i && (r_cch != r_nch)) r_cch <= r_cch + SEL_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_cic_ctrl
// Desc    : Directed self-checking bench for the CIC decimator sequencer
// Rev     : 1.0 - initial release
// ============================================================================
module tb_cic_ctrl;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       cfg_en_i;
  logic       cfg_clr_i;
  logic [1:0] cfg_nch_i;
  logic [9:0] cfg_decim_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic       integ_en_o;
  logic [1:0] integ_sel_o;
  logic       comb_en_o;
  logic [1:0] comb_sel_o;
  logic       clr_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [1:0] out_ch_o;
  logic       ovr_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] obs;
  logic [11:0] want;

  assign obs = {in_ready_o, integ_en_o, integ_sel_o, comb_en_o, comb_sel_o,
                out_valid_o, out_ch_o, clr_o, ovr_o};

  always #5 clk_i = ~clk_i;

  cic_ctrl #(
    .NUM_CH      (4),
    .CNT_W       (10),
    .COMB_STAGES (5)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .cfg_en_i    (cfg_en_i),
    .cfg_clr_i   (cfg_clr_i),
    .cfg_nch_i   (cfg_nch_i),
    .cfg_decim_i (cfg_decim_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .integ_en_o  (integ_en_o),
    .integ_sel_o (integ_sel_o),
    .comb_en_o   (comb_en_o),
    .comb_sel_o  (comb_sel_o),
    .clr_o       (clr_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ch_o    (out_ch_o),
    .ovr_o       (ovr_o)
  );

  // Expected output bundle: ready, integ en/sel, comb en/sel, out valid/ch, clr, ovr.
  function automatic logic [11:0] pk(input logic rdy, input logic ien, input logic [1:0] isel,
                                     input logic cen, input logic [1:0] csel, input logic ov,
                                     input logic [1:0] och, input logic clr, input logic ovr);
    return {rdy, ien, isel, cen, csel, ov, och, clr, ovr};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, want); end
    cyc(); rstn_i = 1'b1;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL idle_after_reset: got %b want %b", obs, want); end
  endtask

  task automatic test_basic();
    cyc(); cfg_nch_i = 2'd1; cfg_decim_i = 10'd3; cfg_en_i = 1'b1;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL basic_idle: got %b want %b", obs, want); end
    for (int i = 0; i < 8; i++) begin
      cyc(); in_valid_i = 1'b1;
      @(negedge clk_i);
      n_checks++; want = pk(1,1,2'(i % 2),0,2'd0,0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL basic_sample[%0d]: got %b want %b", i, obs, want); end
    end
    for (int c = 0; c < 2; c++) begin
      cyc(); in_valid_i = 1'b0; out_ready_i = 1'b0;
      @(negedge clk_i);
      n_checks++; want = pk(0,0,2'd0,1,2'(c),0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL basic_comb_issue[%0d]: got %b want %b", c, obs, want); end
      for (int k = 1; k < 5; k++) begin
        cyc();
        @(negedge clk_i);
        n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,0,0);
        if (obs !== want) begin n_fail++; $display("FAIL basic_comb_wait[%0d.%0d]: got %b want %b", c, k, obs, want); end
      end
      cyc(); out_ready_i = 1'b1;
      @(negedge clk_i);
      n_checks++; want = pk(0,0,2'd0,0,2'd0,1,2'(c),0,0);
      if (obs !== want) begin n_fail++; $display("FAIL basic_out[%0d]: got %b want %b", c, obs, want); end
    end
    cyc(); out_ready_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(1,0,2'd0,0,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL basic_back_to_integ: got %b want %b", obs, want); end
  endtask

  task automatic test_stall_overrun();
    for (int i = 0; i < 8; i++) begin
      cyc(); in_valid_i = 1'b1;
      @(negedge clk_i);
      n_checks++; want = pk(1,1,2'(i % 2),0,2'd0,0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL stall_sample[%0d]: got %b want %b", i, obs, want); end
    end
    cyc(); in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,1,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL stall_comb_issue: got %b want %b", obs, want); end
    repeat (4) cyc();
    for (int j = 0; j < 10; j++) begin
      cyc(); in_valid_i = (j == 2) || (j == 3) || (j == 6);
      @(negedge clk_i);
      n_checks++; want = pk(0,0,2'd0,0,2'd0,1,2'd0,0,(j >= 3));
      if (obs !== want) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b want %b", j, obs, want); end
    end
    cyc(); in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,1,2'd0,0,1);
    if (obs !== want) begin n_fail++; $display("FAIL stall_release: got %b want %b", obs, want); end
    cyc(); out_ready_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,1,2'd1,0,2'd0,0,1);
    if (obs !== want) begin n_fail++; $display("FAIL stall_comb_issue_ch1: got %b want %b", obs, want); end
    repeat (4) cyc();
    cyc(); out_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,1,2'd1,0,1);
    if (obs !== want) begin n_fail++; $display("FAIL stall_out_ch1: got %b want %b", obs, want); end
    // Dropped samples must not have moved the channel pointer.
    for (int i = 0; i < 8; i++) begin
      cyc(); out_ready_i = 1'b0; in_valid_i = 1'b1;
      @(negedge clk_i);
      n_checks++; want = pk(1,1,2'(i % 2),0,2'd0,0,2'd0,0,1);
      if (obs !== want) begin n_fail++; $display("FAIL stall_resume[%0d]: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_clear_comb_wait();
    cyc(); in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,1,2'd0,0,2'd0,0,1);
    if (obs !== want) begin n_fail++; $display("FAIL clr_comb_issue: got %b want %b", obs, want); end
    cyc(); cfg_clr_i = 1'b1; in_valid_i = 1'b1;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,0,1);
    if (obs !== want) begin n_fail++; $display("FAIL clr_request: got %b want %b", obs, want); end
    cyc(); cfg_clr_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,1,0);
    if (obs !== want) begin n_fail++; $display("FAIL clr_pulse: got %b want %b", obs, want); end
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk_i);
      n_checks++; want = pk(1,0,2'd0,0,2'd0,0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL clr_no_out_valid[%0d]: got %b want %b", k, obs, want); end
    end
  endtask

  task automatic test_single_ch();
    cyc(); cfg_en_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL single_en_drop: got %b want %b", obs, want); end
    cyc(); cfg_en_i = 1'b1; cfg_nch_i = 2'd0; cfg_decim_i = 10'd0;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,1,0);
    if (obs !== want) begin n_fail++; $display("FAIL single_clr_pulse: got %b want %b", obs, want); end
    for (int r = 0; r < 2; r++) begin
      cyc(); in_valid_i = 1'b1;
      @(negedge clk_i);
      n_checks++; want = pk(1,1,2'd0,0,2'd0,0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL single_sample[%0d]: got %b want %b", r, obs, want); end
      cyc(); in_valid_i = 1'b0;
      @(negedge clk_i);
      n_checks++; want = pk(0,0,2'd0,1,2'd0,0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL single_comb_issue[%0d]: got %b want %b", r, obs, want); end
      repeat (4) cyc();
      cyc(); out_ready_i = 1'b1;
      @(negedge clk_i);
      n_checks++; want = pk(0,0,2'd0,0,2'd0,1,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL single_out[%0d]: got %b want %b", r, obs, want); end
      cyc(); out_ready_i = 1'b0;
      @(negedge clk_i);
      n_checks++; want = pk(1,0,2'd0,0,2'd0,0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL single_back_to_integ[%0d]: got %b want %b", r, obs, want); end
    end
  endtask

  task automatic test_cfg_change();
    cyc(); cfg_en_i = 1'b0;
    @(negedge clk_i);
    cyc(); cfg_en_i = 1'b1; cfg_nch_i = 2'd1; cfg_decim_i = 10'd3;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,1,0);
    if (obs !== want) begin n_fail++; $display("FAIL cfg_clr_pulse_a: got %b want %b", obs, want); end
    for (int i = 0; i < 6; i++) begin
      cyc(); in_valid_i = 1'b1;
      if (i == 2) cfg_nch_i = 2'd3;
      @(negedge clk_i);
      n_checks++; want = pk(1,1,2'(i % 2),0,2'd0,0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL cfg_ignored[%0d]: got %b want %b", i, obs, want); end
    end
    cyc(); in_valid_i = 1'b0; cfg_en_i = 1'b0;
    @(negedge clk_i);
    cyc(); cfg_en_i = 1'b1;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,1,0);
    if (obs !== want) begin n_fail++; $display("FAIL cfg_clr_pulse_b: got %b want %b", obs, want); end
    for (int i = 0; i < 4; i++) begin
      cyc(); in_valid_i = 1'b1;
      @(negedge clk_i);
      n_checks++; want = pk(1,1,2'(i),0,2'd0,0,2'd0,0,0);
      if (obs !== want) begin n_fail++; $display("FAIL cfg_new_nch[%0d]: got %b want %b", i, obs, want); end
    end
    cyc(); in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(1,0,2'd0,0,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL cfg_still_integ: got %b want %b", obs, want); end
  endtask

  task automatic test_async_reset();
    cyc(); cfg_en_i = 1'b0;
    @(negedge clk_i);
    cyc(); cfg_en_i = 1'b1; cfg_nch_i = 2'd0; cfg_decim_i = 10'd0;
    @(negedge clk_i);
    cyc(); in_valid_i = 1'b1;
    @(negedge clk_i);
    cyc(); in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,1,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL async_comb_issue: got %b want %b", obs, want); end
    repeat (4) cyc();
    cyc(); in_valid_i = 1'b1;
    @(negedge clk_i);
    cyc(); in_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; want = pk(0,0,2'd0,0,2'd0,1,2'd0,0,1);
    if (obs !== want) begin n_fail++; $display("FAIL async_pre_reset: got %b want %b", obs, want); end
    #2; rstn_i = 1'b0;
    #1;
    n_checks++; want = pk(0,0,2'd0,0,2'd0,0,2'd0,0,0);
    if (obs !== want) begin n_fail++; $display("FAIL async_reset_outputs: got %b want %b", obs, want); end
    cyc(); rstn_i = 1'b1; cfg_en_i = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    rstn_i      = 1'b0;
    cfg_en_i    = 1'b0;
    cfg_clr_i   = 1'b0;
    cfg_nch_i   = 2'd0;
    cfg_decim_i = 10'd0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_stall_overrun();
    test_clear_comb_wait();
    test_single_ch();
    test_cfg_change();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
